clint_arb: RTL and testbench

Two-master arbiter and sequencer for the single CLINT slave port. Master 0 is the core LSU data path and master 1 is the debug/difftest access path. The block picks one request at a time with round-robin fairness, registers it, and drives it onto the CLINT for exactly one transaction. It then returns the CLINT read data and response to the winning master as a one-cycle ready pulse. It sits between the LSU/debug address decode and the CLINT, and nothing else drives the CLINT port.

---
 rtl/clint_arb.sv | 190 +++++++++++++++++++
 tb/tb_clint_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_arb.sv
// clint_arb: round-robin two-master arbiter and sequencer for the single CLINT slave port.
// Define CLINT_ARB_TIMEOUT_EN to abort an unanswered ISSUE after TIMEOUT cycles with resp 2'b10.
`ifndef DATA_BUS
`define DATA_BUS 63:0
`endif
`ifndef DATA_ADDR_BUS
`define DATA_ADDR_BUS 63:0
`endif
`ifndef REQ_READ
`define REQ_READ 1'b0
`endif
`ifndef REQ_WRITE
`define REQ_WRITE 1'b1
`endif
`ifndef MTIME_ADDR
`define MTIME_ADDR 64'h0000_0000_0200_bff8
`endif
`ifndef MTIMECMP_ADDR
`define MTIMECMP_ADDR 64'h0000_0000_0200_4000
`endif

module clint_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_valid,
    input  logic                  m0_req,
    input  logic [`DATA_ADDR_BUS] m0_addr,
    input  logic [1:0]            m0_size,
    input  logic [`DATA_BUS]      m0_wdata,
    output logic                  m0_ready,
    output logic [`DATA_BUS]      m0_rdata,
    output logic [1:0]            m0_resp,

    input  logic                  m1_valid,
    input  logic                  m1_req,
    input  logic [`DATA_ADDR_BUS] m1_addr,
    input  logic [1:0]            m1_size,
    input  logic [`DATA_BUS]      m1_wdata,
    output logic                  m1_ready,
    output logic [`DATA_BUS]      m1_rdata,
    output logic [1:0]            m1_resp,

    output logic                  s_valid,
    output logic                  s_req,
    output logic [`DATA_ADDR_BUS] s_addr,
    output logic [1:0]            s_size,
    output logic [`DATA_BUS]      s_wdata,
    input  logic                  s_ready,
    input  logic [`DATA_BUS]      s_rdata,
    input  logic [1:0]            s_resp
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("clint_arb: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  gnt_q, gnt_d;
    logic                  req_q, req_d;
    logic [`DATA_ADDR_BUS] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic [`DATA_BUS]      wdata_q, wdata_d;
    logic                  s_valid_q, s_valid_d;
    logic [`DATA_BUS]      rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic [1:0]            ready_q, ready_d;
`ifdef CLINT_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
    logic [7:0]            cnt_q, cnt_d;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no branch can infer a latch.
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        req_d     = req_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        s_valid_d = s_valid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        ready_d   = 2'b00;
`ifdef CLINT_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the master that did not win last time goes next.
                    gnt_d     = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    last_d    = gnt_d;
                    req_d     = gnt_d ? m1_req   : m0_req;
                    addr_d    = gnt_d ? m1_addr  : m0_addr;
                    size_d    = gnt_d ? m1_size  : m0_size;
                    wdata_d   = gnt_d ? m1_wdata : m0_wdata;
                    s_valid_d = 1'b1;
                    state_d   = ISSUE;
`ifdef CLINT_ARB_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end
            end
            ISSUE: begin
                if (s_ready) begin
                    rdata_d        = s_rdata;
                    resp_d         = s_resp;
                    s_valid_d      = 1'b0;
                    ready_d[gnt_q] = 1'b1;
                    state_d        = RESP;
                end
`ifdef CLINT_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_LIM) begin
                        rdata_d        = '0;
                        resp_d         = 2'b10;
                        s_valid_d      = 1'b0;
                        ready_d[gnt_q] = 1'b1;
                        state_d        = RESP;
                    end
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            s_valid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            ready_q   <= 2'b00;
`ifdef CLINT_ARB_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            s_valid_q <= s_valid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            ready_q   <= ready_d;
`ifdef CLINT_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign s_valid  = s_valid_q;
    assign s_req    = req_q;
    assign s_addr   = addr_q;
    assign s_size   = size_q;
    assign s_wdata  = wdata_q;

    // Return data is visible only to the winner, and only during its ready pulse.
    assign m0_ready = ready_q[0];
    assign m1_ready = ready_q[1];
    assign m0_rdata = ready_q[0] ? rdata_q : '0;
    assign m1_rdata = ready_q[1] ? rdata_q : '0;
    assign m0_resp  = ready_q[0] ? resp_q  : 2'b00;
    assign m1_resp  = ready_q[1] ? resp_q  : 2'b00;

endmodule

// File: tb/tb_clint_arb.sv
// tb_clint_arb: directed scenarios plus random traffic for clint_arb, checked every cycle
// against a transaction-level reference model of the arbitration rules.
`ifndef DATA_BUS
`define DATA_BUS 63:0
`endif
`ifndef DATA_ADDR_BUS
`define DATA_ADDR_BUS 63:0
`endif
`ifndef REQ_READ
`define REQ_READ 1'b0
`endif
`ifndef REQ_WRITE
`define REQ_WRITE 1'b1
`endif
`ifndef MTIME_ADDR
`define MTIME_ADDR 64'h0000_0000_0200_bff8
`endif
`ifndef MTIMECMP_ADDR
`define MTIMECMP_ADDR 64'h0000_0000_0200_4000
`endif

module tb_clint_arb;
    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  t_valid, t_req;
    logic [63:0] t_addr  [2];
    logic [1:0]  t_size  [2];
    logic [63:0] t_wdata [2];
    logic        s_ready;
    logic [63:0] s_rdata;
    logic [1:0]  s_resp;
    logic        m0_ready, m1_ready;
    logic [63:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_resp, m1_resp;
    logic        s_valid, s_req;
    logic [63:0] s_addr, s_wdata;
    logic [1:0]  s_size;
    logic [1:0]  rdy;

    assign rdy = {m1_ready, m0_ready};

    clint_arb #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(t_valid[0]), .m0_req(t_req[0]), .m0_addr(t_addr[0]), .m0_size(t_size[0]),
        .m0_wdata(t_wdata[0]), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_valid(t_valid[1]), .m1_req(t_req[1]), .m1_addr(t_addr[1]), .m1_size(t_size[1]),
        .m1_wdata(t_wdata[1]), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .s_valid(s_valid), .s_req(s_req), .s_addr(s_addr), .s_size(s_size), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata), .s_resp(s_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the transaction in flight and what the outputs must show this cycle.
    logic        e_sv, e_req, e_last, e_win;
    logic [63:0] e_addr, e_wdata, e_rdata;
    logic [1:0]  e_size, e_resp, e_rdy;
    int          e_wait;
    logic [1:0]  outst;
    bit          auto_drop;
    int          cyc;
    int          rlog_id[$];
    int          rlog_cyc[$];

    task automatic model_reset();
        e_sv = 1'b0; e_req = 1'b0; e_last = 1'b1; e_win = 1'b0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
        e_size = '0; e_resp = '0; e_rdy = 2'b00; e_wait = 0;
    endtask

    task automatic model_finish(input logic [63:0] d, input logic [1:0] r);
        e_sv = 1'b0;
        e_rdy = 2'b00;
        e_rdy[e_win] = 1'b1;
        e_rdata = d;
        e_resp = r;
    endtask

    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else if (e_rdy != 2'b00) begin
            e_rdy = 2'b00;
        end else if (e_sv) begin
            if (s_ready) begin
                model_finish(s_rdata, s_resp);
            end else begin
                e_wait++;
`ifdef CLINT_ARB_TIMEOUT_EN
                if (e_wait == TB_TIMEOUT) model_finish(64'd0, 2'b10);
`endif
            end
        end else if (t_valid != 2'b00) begin
            e_win   = (t_valid == 2'b11) ? ~e_last : t_valid[1];
            e_last  = e_win;
            e_sv    = 1'b1;
            e_wait  = 0;
            e_req   = t_req[e_win];
            e_addr  = t_addr[e_win];
            e_size  = t_size[e_win];
            e_wdata = t_wdata[e_win];
            outst[e_win] = 1'b1;
        end
    endtask

    task automatic check_all();
        check("s_valid", 64'(s_valid), 64'(e_sv));
        if (e_sv || !rst) begin
            check("s_req",   64'(s_req),  64'(e_req));
            check("s_addr",  s_addr,      e_addr);
            check("s_size",  64'(s_size), 64'(e_size));
            check("s_wdata", s_wdata,     e_wdata);
        end
        check("m0_ready", 64'(m0_ready), 64'(e_rdy[0]));
        check("m1_ready", 64'(m1_ready), 64'(e_rdy[1]));
        check("m0_rdata", m0_rdata, e_rdy[0] ? e_rdata : 64'd0);
        check("m1_rdata", m1_rdata, e_rdy[1] ? e_rdata : 64'd0);
        check("m0_resp", 64'(m0_resp), 64'(e_rdy[0] ? e_resp : 2'b00));
        check("m1_resp", 64'(m1_resp), 64'(e_rdy[1] ? e_resp : 2'b00));
    endtask

    // One clock: update the model at the edge, compare on the falling edge, log ready pulses.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_all();
        for (int i = 0; i < 2; i++) begin
            if (rdy[i]) begin
                rlog_id.push_back(i);
                rlog_cyc.push_back(cyc);
                outst[i] = 1'b0;
                if (auto_drop) t_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input logic rq, input logic [63:0] a,
                           input logic [1:0] sz, input logic [63:0] wd);
        t_valid[i] = 1'b1;
        t_req[i]   = rq;
        t_addr[i]  = a;
        t_size[i]  = sz;
        t_wdata[i] = wd;
    endtask

    initial begin
        int svc;
        int n;
        t_valid = '0; t_req = '0;
        for (int i = 0; i < 2; i++) begin
            t_addr[i] = '0; t_size[i] = '0; t_wdata[i] = '0;
        end
        s_ready = 1'b0; s_rdata = '0; s_resp = '0;
        auto_drop = 1'b1; outst = '0; cyc = 0;
        model_reset();
        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Tie from reset: grants alternate m0, m1, ... three cycles apart.
        s_ready = 1'b1; s_rdata = 64'hA5; s_resp = 2'b00;
        auto_drop = 1'b0;
        rlog_id.delete(); rlog_cyc.delete();
        set_req(0, `REQ_READ, `MTIME_ADDR, 2'd3, 64'd0);
        set_req(1, `REQ_READ, `MTIMECMP_ADDR, 2'd3, 64'd0);
        repeat (13) step();
        check("rr_count", 64'(rlog_id.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < rlog_id.size()) begin
                check("rr_id", 64'(rlog_id[k]), 64'(k % 2));
                if (k > 0) check("rr_gap", 64'(rlog_cyc[k] - rlog_cyc[k-1]), 64'd3);
            end
        end
        auto_drop = 1'b1;
        t_valid = '0;
        repeat (4) step();

        // Single read of mtime answered in the first ISSUE cycle.
        s_ready = 1'b1; s_rdata = 64'h1234; s_resp = 2'b00;
        set_req(0, `REQ_READ, `MTIME_ADDR, 2'd3, 64'd0);
        step();
        check("rd_svalid", 64'(s_valid), 64'd1);
        check("rd_addr", s_addr, `MTIME_ADDR);
        step();
        check("rd_ready0", 64'(m0_ready), 64'd1);
        check("rd_rdata", m0_rdata, 64'h1234);
        check("rd_resp", 64'(m0_resp), 64'd0);
        check("rd_ready1", 64'(m1_ready), 64'd0);
        step();
        check("rd_svalid_off", 64'(s_valid), 64'd0);

        // Write pass-through from m1.
        rlog_id.delete(); rlog_cyc.delete();
        set_req(1, `REQ_WRITE, `MTIMECMP_ADDR, 2'd3, 64'd500);
        svc = 0;
        repeat (5) begin
            step();
            if (s_valid) begin
                svc++;
                check("wr_req", 64'(s_req), 64'(`REQ_WRITE));
                check("wr_wdata", s_wdata, 64'd500);
            end
        end
        check("wr_svalid_cycles", 64'(svc), 64'd1);
        check("wr_pulses", 64'(rlog_id.size()), 64'd1);
        if (rlog_id.size() > 0) check("wr_pulse_id", 64'(rlog_id[0]), 64'd1);

`ifndef CLINT_ARB_TIMEOUT_EN
        // Stalled slave: five ISSUE cycles without s_ready, answered in the sixth.
        s_ready = 1'b0;
        set_req(0, `REQ_READ, `MTIME_ADDR, 2'd2, 64'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("st_svalid", 64'(s_valid), 64'd1);
            check("st_addr", s_addr, `MTIME_ADDR);
            check("st_size", 64'(s_size), 64'd2);
        end
        s_ready = 1'b1; s_rdata = 64'h77; s_resp = 2'b01;
        step();
        check("st_ready", 64'(m0_ready), 64'd1);
        check("st_rdata", m0_rdata, 64'h77);
        s_ready = 1'b0;
        step();

        // Without the timeout an unanswered request waits indefinitely.
        set_req(0, `REQ_READ, `MTIME_ADDR, 2'd3, 64'd0);
        step();
        repeat (100) step();
        check("hang_svalid", 64'(s_valid), 64'd1);
        check("hang_ready", 64'(rdy), 64'd0);
        s_ready = 1'b1;
        repeat (2) step();
`else
        // Timeout: no s_ready ever; error response after TB_TIMEOUT ISSUE cycles.
        s_ready = 1'b0;
        set_req(0, `REQ_READ, `MTIME_ADDR, 2'd3, 64'd0);
        step();
        n = 0;
        while (!m0_ready && n < 20) begin
            step();
            n++;
        end
        check("to_latency", 64'(n), 64'(TB_TIMEOUT));
        check("to_resp", 64'(m0_resp), 64'd2);
        check("to_rdata", m0_rdata, 64'd0);
        step();
`endif

        // Reset during ISSUE aborts; a held m1 request is regranted after release.
        s_ready = 1'b0;
        set_req(1, `REQ_READ, `MTIME_ADDR, 2'd3, 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rs_svalid", 64'(s_valid), 64'd0);
        check("rs_addr", s_addr, 64'd0);
        check("rs_ready", 64'(rdy), 64'd0);
        check("rs_resp", 64'(m1_resp), 64'd0);
        model_reset();
        outst = '0;
        repeat (2) step();
        rst = 1'b1;
        s_ready = 1'b1; s_rdata = 64'h55; s_resp = 2'b00;
        rlog_id.delete(); rlog_cyc.delete();
        step();
        check("rs_regrant", 64'(s_valid), 64'd1);
        repeat (4) step();
        check("rs_pulses", 64'(rlog_id.size()), 64'd1);
        if (rlog_id.size() > 0) check("rs_pulse_id", 64'(rlog_id[0]), 64'd1);

        // Random traffic, including masters abandoning valid mid-transaction.
        auto_drop = 1'b0;
        t_valid = '0;
        outst = '0;
        repeat (1500) begin
            step();
            s_ready = ($urandom_range(0, 9) < 6);
            s_rdata = {$urandom, $urandom};
            s_resp  = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                if (rdy[i]) t_valid[i] = 1'b0;
                if (!t_valid[i] && !outst[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                                2'($urandom_range(0, 3)), {$urandom, $urandom});
                end else if (t_valid[i] && outst[i] && $urandom_range(0, 15) == 0) begin
                    t_valid[i] = 1'b0;
                end
            end
        end
        t_valid = '0;
        s_ready = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
